// File: rtl/aes_pkg.sv
// Shared types and constants for the AES stream sequencer and its output register.
package aes_pkg;
  localparam int BLK_W = 128;
  localparam int KEY_W = 256;

  localparam logic [1:0] AES_128 = 2'd0;
  localparam logic [1:0] AES_192 = 2'd1;
  localparam logic [1:0] AES_256 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HOLD
  } state_e;
endpackage

// File: rtl/aes_cbc_sequencer_if.sv
// Input and output block streams of the AES sequencer (valid/ready on both sides).
interface aes_cbc_sequencer_if;
  import aes_pkg::*;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [BLK_W-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [BLK_W-1:0] out_data_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/aes_out_reg.sv
// One-entry output register; data is held stable until the downstream takes it.
module aes_out_reg
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [BLK_W-1:0] wr_data,
  output logic             free,
  output logic             valid,
  output logic [BLK_W-1:0] data,
  input  logic             ready
);

  // A same-cycle drain frees the slot, so a write may land on the draining edge.
  assign free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_cbc_sequencer.sv
// Stream front end for an iterative AES core: one block in flight, ECB/CBC chaining
// for encrypt and decrypt, timeout abort while waiting on the core.
module aes_cbc_sequencer
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  aes_cbc_sequencer_if.slave s,
  input  logic [KEY_W-1:0] key_i,
  input  logic [1:0]       size_i,
  input  logic             dec_i,
  input  logic             cbc_i,
  input  logic [BLK_W-1:0] iv_i,
  input  logic             iv_load_i,
  output logic             core_load_o,
  output logic [KEY_W-1:0] core_key_o,
  output logic [BLK_W-1:0] core_data_o,
  output logic [1:0]       core_size_o,
  output logic             core_dec_o,
  input  logic [BLK_W-1:0] core_data_i,
  input  logic             core_busy_i,
  output logic             err_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e           state, state_d;
  logic [BLK_W-1:0] pend, chain, result;
  logic [KEY_W-1:0] key_q;
  logic [1:0]       size_q;
  logic             dec_q, cbc_q;
  logic [CNT_W-1:0] tcnt;
  logic             err_q;
  logic             accept, capture, abort, out_free;

  assign accept = (state == ST_IDLE) && s.in_valid_i;

  always_comb begin
    state_d = state;
    capture = 1'b0;
    abort   = 1'b0;
    case (state)
      ST_IDLE: if (s.in_valid_i) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (!core_busy_i) begin
          if (out_free) begin
            capture = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end else if (tcnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_free) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Config and pend are frozen from accept until the next accept, so the core pins
  // and core_data_o stay constant from LOAD through capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= '0;
      chain  <= '0;
      key_q  <= '0;
      size_q <= '0;
      dec_q  <= 1'b0;
      cbc_q  <= 1'b0;
      tcnt   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        pend   <= s.in_data_i;
        key_q  <= key_i;
        size_q <= size_i;
        dec_q  <= dec_i;
        cbc_q  <= cbc_i;
      end else if ((state == ST_IDLE) && iv_load_i) begin
        chain <= iv_i;
        err_q <= 1'b0;
      end
      if (state == ST_LOAD)     tcnt <= '0;
      else if (state == ST_RUN) tcnt <= tcnt + 1'b1;
      if (abort) err_q <= 1'b1;
      if (capture && cbc_q) chain <= dec_q ? pend : core_data_i;
    end
  end

  assign result      = (cbc_q && dec_q) ? (core_data_i ^ chain) : core_data_i;
  assign core_data_o = (cbc_q && !dec_q) ? (pend ^ chain) : pend;
  assign core_load_o = (state == ST_LOAD);
  assign core_key_o  = key_q;
  assign core_size_o = size_q;
  assign core_dec_o  = dec_q;
  assign s.in_ready_o = (state == ST_IDLE);
  assign busy_o      = (state != ST_IDLE);
  assign err_o       = err_q;

  aes_out_reg u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (result),
    .free    (out_free),
    .valid   (s.out_valid_o),
    .data    (s.out_data_o),
    .ready   (s.out_ready_i)
  );

endmodule

// File: tb/tb_aes_cbc_sequencer.sv
// Bench for aes_cbc_sequencer: a lookup-table AES core model, vector table with an
// output scoreboard, and hand-written backpressure, timeout and reset sequences.
module tb_aes_cbc_sequencer;
  import aes_pkg::*;

  localparam int TO = 64;

  localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K2  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KR  = 256'hdeadbeef_01234567_89abcdef_cafef00d_13572468_9bdf0ace_55aa55aa_0f1e2d3c;
  localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] DR  = 128'h0123456789abcdeffedcba9876543210;

  typedef struct {
    logic [255:0] key;
    logic [1:0]   size;
    logic         dec;
    logic         cbc;
    logic         iv_load;
    logic [127:0] iv;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [255:0] key_i;
  logic [1:0]   size_i;
  logic         dec_i, cbc_i, iv_load_i;
  logic [127:0] iv_i;
  logic         core_load_o, core_dec_o, core_busy_i, err_o, busy_o;
  logic [255:0] core_key_o;
  logic [127:0] core_data_o, core_data_i;
  logic [1:0]   core_size_o;

  aes_cbc_sequencer_if bus ();

  aes_cbc_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (bus),
    .key_i       (key_i),
    .size_i      (size_i),
    .dec_i       (dec_i),
    .cbc_i       (cbc_i),
    .iv_i        (iv_i),
    .iv_load_i   (iv_load_i),
    .core_load_o (core_load_o),
    .core_key_o  (core_key_o),
    .core_data_o (core_data_o),
    .core_size_o (core_size_o),
    .core_dec_o  (core_dec_o),
    .core_data_i (core_data_i),
    .core_busy_i (core_busy_i),
    .err_o       (err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Known AES block pairs the core model can answer: key, plaintext, ciphertext.
  logic [255:0] pk [3];
  logic [127:0] pp [3];
  logic [127:0] pc [3];

  function automatic logic [127:0] fb(input logic [127:0] d, input logic [255:0] k);
    return ~d ^ k[255:128] ^ k[127:0];
  endfunction

  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [127:0] d,
                                           input logic dec);
    for (int i = 0; i < 3; i++) begin
      if (k == pk[i] && !dec && d == pp[i]) return pc[i];
      if (k == pk[i] && dec && d == pc[i]) return pp[i];
    end
    return fb(d, k);
  endfunction

  // Core model: busy is registered off the load strobe, result valid once busy falls.
  logic         m_busy = 1'b0;
  int           m_cnt = 0;
  logic [127:0] m_res = '0;
  logic         force_busy = 1'b0;
  int           load_cnt = 0;
  int           stab_err = 0;
  logic [255:0] ld_key = '0;
  logic [1:0]   ld_size = '0;
  logic         ld_dec = 1'b0;

  always @(posedge clk) begin
    if (core_load_o) begin
      load_cnt <= load_cnt + 1;
      ld_key   <= core_key_o;
      ld_size  <= core_size_o;
      ld_dec   <= core_dec_o;
      m_res    <= core_fn(core_key_o, core_data_o, core_dec_o);
      m_busy   <= 1'b1;
      m_cnt    <= 10 + 2 * int'(core_size_o);
    end else if (m_busy) begin
      if (busy_o && (core_key_o !== ld_key || core_size_o !== ld_size || core_dec_o !== ld_dec))
        stab_err <= stab_err + 1;
      if (m_cnt <= 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end
  end

  assign core_busy_i = m_busy | force_busy;
  assign core_data_i = m_busy ? ~m_res : m_res;

  logic [127:0] expq [$];
  logic [127:0] mon_exp;

  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got %h, no block expected", bus.out_data_o);
      end else begin
        mon_exp = expq.pop_front();
        if (bus.out_data_o !== mon_exp) begin
          fails++;
          $display("FAIL out_data: got %h, expected %h", bus.out_data_o, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic send(input vec_t v, input bit push);
    if (v.iv_load) begin
      wait_ready();
      iv_i = v.iv;
      iv_load_i = 1'b1;
      @(posedge clk); #1;
      iv_load_i = 1'b0;
    end
    wait_ready();
    if (!bus.in_ready_o) begin
      tests++;
      fails++;
      $display("FAIL accept_wait: in_ready_o stayed %b, expected 1", bus.in_ready_o);
    end
    key_i = v.key;
    size_i = v.size;
    dec_i = v.dec;
    cbc_i = v.cbc;
    bus.in_data_i = v.din;
    bus.in_valid_i = 1'b1;
    if (push) expq.push_back(v.dout);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    int n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, expq.size(), 0);
  endtask

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc0, n;
    logic [127:0] d0;
    bit stable, hold_ok;

    pk[0] = K1; pp[0] = PT0;      pc[0] = CT0;
    pk[1] = K2; pp[1] = P1 ^ IV;  pc[1] = C1;
    pk[2] = K2; pp[2] = P2 ^ C1;  pc[2] = C2;

    vecs[0] = '{K1, 2'd0, 1'b0, 1'b0, 1'b0, 128'h0, PT0, CT0};
    vecs[1] = '{K1, 2'd0, 1'b1, 1'b0, 1'b0, 128'h0, CT0, PT0};
    vecs[2] = '{K2, 2'd0, 1'b0, 1'b1, 1'b1, IV,     P1,  C1};
    vecs[3] = '{K2, 2'd0, 1'b0, 1'b1, 1'b0, 128'h0, P2,  C2};
    vecs[4] = '{K2, 2'd0, 1'b1, 1'b1, 1'b1, IV,     C1,  P1};
    vecs[5] = '{K1, 2'd1, 1'b0, 1'b0, 1'b0, 128'h0, PT0, CT0};
    vecs[6] = '{K2, 2'd0, 1'b1, 1'b1, 1'b0, 128'h0, C2,  P2};
    vecs[7] = '{KR, 2'd3, 1'b1, 1'b0, 1'b0, 128'h0, DR,  fb(DR, KR)};

    rst = 1'b1;
    key_i = '0; size_i = '0; dec_i = 1'b0; cbc_i = 1'b0;
    iv_i = '0; iv_load_i = 1'b0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.out_ready_i = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", bus.in_ready_o, 1);
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_out_data", bus.out_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_core_load", core_load_o, 0);
    chk("rst_core_data", core_data_o, 0);
    chk("rst_core_key", core_key_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      lc0 = load_cnt;
      send(vecs[i], 1'b1);
      wait_out($sformatf("v%0d", i));
      chk($sformatf("v%0d_loads", i), load_cnt, lc0 + 1);
      chk($sformatf("v%0d_size", i), ld_size, vecs[i].size);
      chk($sformatf("v%0d_dec", i), ld_dec, vecs[i].dec);
      chk($sformatf("v%0d_key", i), ld_key, vecs[i].key);
    end

    // Backpressure: first result parks in the output register, second waits in HOLD.
    bus.out_ready_i = 1'b0;
    lc0 = load_cnt;
    send(vecs[0], 1'b1);
    send(vecs[1], 1'b1);
    repeat (25) @(posedge clk);
    #1;
    d0 = bus.out_data_o;
    stable = 1'b1;
    hold_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_data_o !== d0 || !bus.out_valid_o) stable = 1'b0;
      if (!busy_o || bus.in_ready_o) hold_ok = 1'b0;
    end
    chk("bp_first_data", d0, CT0);
    chk("bp_data_stable", stable, 1);
    chk("bp_held_busy", hold_ok, 1);
    chk("bp_loads", load_cnt, lc0 + 2);
    bus.out_ready_i = 1'b1;
    wait_out("bp");

    // Timeout with the core stuck busy.
    force_busy = 1'b1;
    send(vecs[0], 1'b0);
    n = 0;
    while (!err_o && n < TO + 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("to_latency_in_range", (n >= TO && n <= TO + 2), 1);
    chk("to_err", err_o, 1);
    chk("to_idle", busy_o, 0);
    chk("to_in_ready", bus.in_ready_o, 1);
    chk("to_no_output", bus.out_valid_o, 0);
    force_busy = 1'b0;
    iv_i = IV;
    iv_load_i = 1'b1;
    @(posedge clk); #1;
    iv_load_i = 1'b0;
    chk("to_err_cleared", err_o, 0);
    send(vecs[2], 1'b1);
    wait_out("to_recover");

    // Reset while a result is pending and the next block is in RUN.
    bus.out_ready_i = 1'b0;
    send(vecs[0], 1'b0);
    n = 0;
    while (!bus.out_valid_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mr_first_valid", bus.out_valid_o, 1);
    send(vecs[1], 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_in_ready", bus.in_ready_o, 1);
    chk("mr_out_valid", bus.out_valid_o, 0);
    chk("mr_out_data", bus.out_data_o, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_core_load", core_load_o, 0);
    chk("mr_core_data", core_data_o, 0);
    chk("mr_core_key", core_key_o, 0);
    chk("mr_err", err_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_no_stale_output", bus.out_valid_o, 0);
    lc0 = load_cnt;
    send(vecs[0], 1'b1);
    wait_out("mr_next");
    chk("mr_next_loads", load_cnt, lc0 + 1);

    chk("core_pins_stable", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
